// File: rtl/bus_transfer_arbiter.sv
// bus_transfer_arbiter: round-robin arbiter that sequences one Bus transfer per grant.
// Latency: legal transfer takes 4 cycles IDLE->SRC->DST->DONE; an illegal source is rejected in 2 cycles IDLE->DONE.
// Backpressure: a requester holds req until done. Inputs are sampled only in IDLE, and later changes are ignored.
//
// Ports:
//   i_clock, i_reset            clock; synchronous active-high reset
//   i_req / i_req_src / i_req_dst
//                               per-requester request, packed source and destination codes
//   o_gnt, o_done, o_err        one-hot grant, one-hot completion pulse, illegal-source flag
//   o_select_source             drives the Bus select_source input
//   o_select_destination        drives the Bus select_destination input
//   o_busy                      high whenever the FSM is outside IDLE
module bus_transfer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 4,
  parameter int DST_W   = 3
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*SRC_W-1:0] i_req_src,
  input  logic [NUM_REQ*DST_W-1:0] i_req_dst,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_err,
  output logic [SRC_W-1:0]         o_select_source,
  output logic [DST_W-1:0]         o_select_destination,
  output logic                     o_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_SRC, S_DST, S_DONE} state_t;

  state_t               r_state, w_state;
  logic [PTR_W-1:0]     r_ptr, w_ptr;
  logic [PTR_W-1:0]     r_win, w_win;
  logic [DST_W-1:0]     r_dst, w_dst;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt;
  logic [NUM_REQ-1:0]   r_done, w_done;
  logic                 r_err, w_err;
  logic [SRC_W-1:0]     r_sel_src, w_sel_src;
  logic [DST_W-1:0]     r_sel_dst, w_sel_dst;
  logic                 r_busy;

  logic [SRC_W-1:0]     w_srcs [NUM_REQ];
  logic [DST_W-1:0]     w_dsts [NUM_REQ];
  logic                 w_found;
  logic [PTR_W-1:0]     w_pick;
  logic [PTR_W:0]       w_sum;
  logic [SRC_W-1:0]     w_pick_src;
  logic [DST_W-1:0]     w_pick_dst;

  // Legal sources: 1, 2, 3 and 5..11. Codes 0, 4 and 12..15 are rejected.
  function automatic logic f_src_legal(input logic [SRC_W-1:0] s);
    return (s == SRC_W'(1)) || (s == SRC_W'(2)) || (s == SRC_W'(3)) ||
           ((s >= SRC_W'(5)) && (s <= SRC_W'(11)));
  endfunction

  // Undefined destinations are quietly replaced by 0, which means "load bus only".
  function automatic logic f_dst_legal(input logic [DST_W-1:0] d);
    return (d == DST_W'(0)) || (d == DST_W'(2)) || (d == DST_W'(3)) || (d == DST_W'(6));
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_srcs[i] = i_req_src[i*SRC_W +: SRC_W];
      w_dsts[i] = i_req_dst[i*DST_W +: DST_W];
    end
  end

  // Round-robin search that starts at r_ptr. The sum is one bit wider
  // than the pointer so that a non-power-of-two NUM_REQ wraps correctly.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end
      if (!w_found && i_req[w_sum[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[PTR_W-1:0];
      end
    end
    w_pick_src = w_srcs[w_pick];
    w_pick_dst = f_dst_legal(w_dsts[w_pick]) ? w_dsts[w_pick] : '0;
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    w_state   = r_state;
    w_ptr     = r_ptr;
    w_win     = r_win;
    w_dst     = r_dst;
    w_gnt     = r_gnt;
    w_done    = r_done;
    w_err     = r_err;
    w_sel_src = r_sel_src;
    w_sel_dst = r_sel_dst;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_win = w_pick;
          w_dst = w_pick_dst;
          if (f_src_legal(w_pick_src)) begin
            w_state   = S_SRC;
            w_gnt     = NUM_REQ'(1) << w_pick;
            w_sel_src = w_pick_src;
            w_sel_dst = '0;
          end else begin
            // The request is rejected without touching the Bus.
            w_state = S_DONE;
            w_done  = NUM_REQ'(1) << w_pick;
            w_err   = 1'b1;
          end
        end
      end
      S_SRC: begin
        w_state   = S_DST;
        w_sel_src = '0;
        w_sel_dst = r_dst;
      end
      S_DST: begin
        w_state   = S_DONE;
        w_sel_dst = '0;
        w_gnt     = '0;
        w_done    = NUM_REQ'(1) << r_win;
        w_err     = 1'b0;
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_done  = '0;
        w_err   = 1'b0;
        w_ptr   = (r_win == PTR_W'(NUM_REQ-1)) ? '0 : r_win + 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_dst     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_sel_src <= '0;
      r_sel_dst <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ptr     <= w_ptr;
      r_win     <= w_win;
      r_dst     <= w_dst;
      r_gnt     <= w_gnt;
      r_done    <= w_done;
      r_err     <= w_err;
      r_sel_src <= w_sel_src;
      r_sel_dst <= w_sel_dst;
      r_busy    <= (w_state != S_IDLE);
    end
  end

  assign o_gnt                = r_gnt;
  assign o_done               = r_done;
  assign o_err                = r_err;
  assign o_select_source      = r_sel_src;
  assign o_select_destination = r_sel_dst;
  assign o_busy               = r_busy;

endmodule

// File: doc/bus_transfer_arbiter.md
Name: bus_transfer_arbiter

Overview:
- Shares the single-value datapath Bus between NUM_REQ requesters, each asking for one transfer: a source code plus a destination code.
- Arbitrates round-robin and sequences each transfer over the Bus's posedge-source / negedge-destination timing by driving select_source and select_destination.
- Returns a done pulse to the winner, with an error flag for illegal source codes.
- Sits between control-unit micro-sequencers (and the DMA/downsampling engines) and the Bus select inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SRC_W, 4, width of select_source code.
- DST_W, 3, width of select_destination code.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester transfer request; held until matching done.
- req_src  input  NUM_REQ*SRC_W  source code of requester i at bits [i*SRC_W +: SRC_W].
- req_dst  input  NUM_REQ*DST_W  destination code of requester i at bits [i*DST_W +: DST_W].
- gnt  output  NUM_REQ  one-hot grant; high while the winner's transfer occupies the Bus.
- done  output  NUM_REQ  one-cycle completion pulse to the winner.
- err  output  1  high with done when the winner's source code was illegal.
- select_source  output  SRC_W  to Bus select_source.
- select_destination  output  DST_W  to Bus select_destination.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronous; state=IDLE, rr_ptr=0, gnt=0, done=0, err=0, select_source=0000 (hold), select_destination=000 (none), busy=0. All outputs are registered.
- Reset mid-transfer: the sequence is abandoned with no done pulse. Selects return to 0000/000 after the reset edge.
- Legal source codes: 0001, 0010, 0011, 0101–1011.
- Illegal source codes: 0000, 0100, 1100–1111.
- Legal destination codes: 000 (load bus only), 010, 011, 110.
- Any other destination code is forced to 000. It is not flagged as an error.
- States: IDLE, SRC, DST, DONE.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise pick the first asserted req[i], scanning i = rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
  - Latch winner index, src and dst.
  - If src is legal: next state SRC, gnt[winner]=1, select_source=src, select_destination=000.
  - If src is illegal: next state DONE with err=1, no gnt, selects stay 0000/000.
- SRC: one cycle. The Bus loads value at the next edge.
  - Next state DST.
  - Outputs at that edge: select_source=0000, select_destination=dst_latched, gnt held.
- DST: one cycle. The Bus destination latches on the falling edge in this cycle.
  - Next state DONE.
  - Outputs at that edge: select_destination=000, gnt=0, done[winner]=1.
- DONE: one cycle.
  - done[winner] is high and err is valid.
  - rr_ptr = (winner+1) mod NUM_REQ.
  - Next state IDLE; done and err clear at that edge.
- Latency: req sampled at edge 0 → select_source valid after edge 0 → select_destination valid after edge 1 → done after edge 2.
  - Back in IDLE after edge 3.
  - Legal transfer: 4 cycles; illegal-source reject: 2 cycles.
- Request rules:
  - req/req_src/req_dst are sampled only in IDLE; changes afterwards are ignored.
  - Dropping req mid-transfer does not abort; done still pulses.
  - A requester that keeps req high after done is re-arbitrated fairly; back-to-back transfers from the same requester are allowed only when no other requester is asserting req.
- Simultaneous requests: round-robin. Any continuously asserted requester is served within NUM_REQ transfers.
- Invariants:
  - gnt is at most one-hot.
  - done is at most one-hot.
  - select_source and select_destination are never both non-zero in the same cycle.

Test Plan:
- Reset, then req=0001, src0=0001 (AC), dst0=010 (R1) → select_source=0001 for 1 cycle, then select_destination=010 for 1 cycle, then done[0] for 1 cycle. err=0 and gnt[0] high for exactly 2 cycles. With a Bus model, R1_out ends equal to AC_in.
- req=1111 held constantly, all src legal → grant order 0,1,2,3,0. Each transfer is 4 cycles and done is one-hot each time.
- req=0100, src2=0100 → no gnt and no selects. done[2]=1 with err=1 two cycles after sampling, then back to IDLE.
- req=0010, dst1=101 (undefined) → select_destination stays 000, done[1]=1, err=0.
- Assert reset during DST of a transfer → selects=0000/000, gnt=0, done=0 after the edge. A subsequent req starts from rr_ptr=0.
- req1 deasserted during SRC → transfer still completes; done[1] pulses and rr_ptr advances to 2.
